data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM for a small core plus an MMIO
// window holding a store-out FIFO (TXDATA), a status/drop-count register
// (STATUS) and a free-running cycle counter (CYCLES).
module data_mem_responder #(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        store_drop
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] CYCLES_ADDR = MMIO_BASE + 32'h8;

  // Architectural state
  logic [31:0]      mem_q    [MEM_WORDS];
  logic [31:0]      mem_d    [MEM_WORDS];
  logic [31:0]      fifo_q   [FIFO_DEPTH];
  logic [31:0]      fifo_d   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             store_drop_q, store_drop_d;
  logic [31:0]      cycles_q, cycles_d;

  // Address decode and handshake terms
  logic             is_ram, is_tx, is_status, is_cycles;
  logic [IDX_W-1:0] ram_idx;
  logic             fifo_full, fifo_empty;
  logic             pop, tx_store, push_ok, drop;
  logic [2:0]       count_field;
  logic [31:0]      status_word;
  logic             unused_addr_lsbs;

  // Byte-lane bits never participate in decode; all accesses are full words.
  assign unused_addr_lsbs = ^A[1:0];

  assign is_ram    = (A < MMIO_BASE);
  assign is_tx     = (A[31:2] == TXDATA_ADDR[31:2]);
  assign is_status = (A[31:2] == STATUS_ADDR[31:2]);
  assign is_cycles = (A[31:2] == CYCLES_ADDR[31:2]);
  assign ram_idx   = A[IDX_W+1:2];

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // A pop on the same edge frees a slot, so a store to a full FIFO is still
  // accepted when the consumer drains one entry simultaneously.
  assign pop      = !fifo_empty && tx_ready;
  assign tx_store = is_tx && WE;
  assign push_ok  = tx_store && (!fifo_full || pop);
  assign drop     = tx_store && fifo_full && !pop;

  // STATUS count field is three bits wide, sized for the default depth.
  assign count_field = 3'(count_q);
  assign status_word = {16'h0, drop_cnt_q, 2'b00, fifo_empty, fifo_full,
                        1'b0, count_field};

  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_q[rd_ptr_q] : 32'h0;
  assign store_drop = store_drop_q;

  // Combinational load data: RAM word, STATUS, CYCLES, or zero elsewhere.
  always_comb begin
    RD = 32'h0;
    if (is_ram) begin
      RD = mem_q[ram_idx];
    end else if (is_status) begin
      RD = status_word;
    end else if (is_cycles) begin
      RD = cycles_q;
    end
  end

  // Next-state for RAM contents: word write on a store below the MMIO window.
  always_comb begin
    mem_d = mem_q;
    if (WE && is_ram) begin
      mem_d[ram_idx] = WD;
    end
  end

  // Next-state for FIFO storage, pointers and occupancy.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    if (push_ok) begin
      fifo_d[wr_ptr_q] = WD;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Next-state for drop accounting and the cycle counter.
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    store_drop_d = drop;
    cycles_d     = cycles_q + 32'h1;
    if (is_status && WE && WD[0]) begin
      drop_cnt_d = 8'h00;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'h01;
    end
  end

  // State registers; reset clears everything including RAM and FIFO entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q        <= '{default: '0};
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      store_drop_q <= 1'b0;
      cycles_q     <= '0;
    end else begin
      mem_q        <= mem_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      store_drop_q <= store_drop_d;
      cycles_q     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus random traffic,
// checked against a queue/array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        store_drop;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [31:0] m_mem [64];
  logic [31:0] m_q [$];
  int          m_drop;
  bit          m_pend;
  logic [31:0] m_cyc;

  data_mem_responder #(
    .MEM_WORDS (64),
    .FIFO_DEPTH(4),
    .MMIO_BASE (32'h0000_0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RD        (RD),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .store_drop(store_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = 32'h0;
    s[15:8] = 8'(m_drop);
    s[5]    = (m_q.size() == 0);
    s[4]    = (m_q.size() == 4);
    s[2:0]  = 3'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'h100) return m_mem[a[7:2]];
    if (a[31:2] == 30'h41) return m_status();
    if (a[31:2] == 30'h42) return m_cyc;
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    m_q.delete();
    m_drop = 0;
    m_pend = 1'b0;
    m_cyc  = 32'h0;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
    bit pop;
    bit drop;
    A = a; WD = wd; WE = we; tx_ready = rdy;
    #1;
    check("rd", RD, m_read(a));
    check("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
    if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
    check("store_drop", {31'h0, store_drop}, {31'h0, m_pend});
    @(posedge clk);
    pop  = (m_q.size() != 0) && rdy;
    drop = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (we && a[31:2] == 30'h40) begin
      if (m_q.size() < 4) m_q.push_back(wd);
      else drop = 1'b1;
    end
    if (we && a[31:2] == 30'h41 && wd[0]) m_drop = 0;
    else if (drop && m_drop < 255) m_drop++;
    if (we && a < 32'h100) m_mem[a[7:2]] = wd;
    m_pend = drop;
    m_cyc  = m_cyc + 32'h1;
    #1;
  endtask

  // Combinational look at a read address without advancing the clock.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    A = a; WE = 1'b0;
    #1;
    check(tag, RD, exp);
  endtask

  initial begin
    logic [31:0] drain_exp [4];
    logic [31:0] a;
    n_cmp = 0;
    n_bad = 0;
    drain_exp = '{32'h22, 32'h33, 32'h44, 32'h66};

    // Power-on reset state
    rst = 1'b0; A = 32'h104; WD = 32'h0; WE = 1'b0; tx_ready = 1'b0;
    m_reset();
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_store_drop", {31'h0, store_drop}, 32'h0);
    check("rst_status", RD, 32'h0000_0020);
    @(negedge clk);
    rst = 1'b1;

    // Cycle counter after ten edges
    for (int i = 0; i < 10; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    peek("cycles10", 32'h108, 32'd10);

    // RAM store / load with ignored byte offset
    step(32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0);
    peek("ram_load", 32'h8, 32'hDEAD_BEEF);
    peek("ram_load_b", 32'hB, 32'hDEAD_BEEF);

    // Fill FIFO, then overflow
    step(32'h100, 32'h11, 1'b1, 1'b0);
    step(32'h100, 32'h22, 1'b1, 1'b0);
    step(32'h100, 32'h33, 1'b1, 1'b0);
    step(32'h100, 32'h44, 1'b1, 1'b0);
    peek("status_full", 32'h104, 32'h0000_0014);
    step(32'h100, 32'h55, 1'b1, 1'b0);
    check("drop_pulse", {31'h0, store_drop}, 32'h1);
    peek("status_drop1", 32'h104, 32'h0000_0114);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    check("drop_pulse_end", {31'h0, store_drop}, 32'h0);

    // Push and pop on the same edge while full
    step(32'h100, 32'h66, 1'b1, 1'b1);
    check("no_drop_full_pop", {31'h0, store_drop}, 32'h0);
    peek("status_still_full", 32'h104, 32'h0000_0114);
    for (int i = 0; i < 4; i++) begin
      A = 32'h0; WE = 1'b0; tx_ready = 1'b1;
      #1;
      check("drain_order", tx_data, drain_exp[i]);
      step(32'h0, 32'h0, 1'b0, 1'b1);
    end
    check("drained_empty", {31'h0, tx_valid}, 32'h0);

    // No bypass into empty FIFO
    step(32'h100, 32'hA5, 1'b1, 1'b1);
    check("nobypass_valid", {31'h0, tx_valid}, 32'h1);
    check("nobypass_data", tx_data, 32'hA5);
    step(32'h0, 32'h0, 1'b0, 1'b1);
    check("nobypass_fall", {31'h0, tx_valid}, 32'h0);

    // Two more drops (count -> 3), then clear through STATUS
    for (int i = 0; i < 6; i++) step(32'h100, 32'h70 + i, 1'b1, 1'b0);
    peek("status_drop3", 32'h104, 32'h0000_0314);
    step(32'h104, 32'h1, 1'b1, 1'b0);
    peek("status_cleared", 32'h104, 32'h0000_0014);
    peek("unmapped_10c", 32'h10C, 32'h0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(32'h100, i, 1'b1, 1'b0);
    peek("drop_saturate", 32'h104, 32'h0000_FF14);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = {24'h0, 8'($urandom_range(0, 255))};
        2, 3:    a = 32'h100 | 32'($urandom_range(0, 3));
        4:       a = 32'h104 | 32'($urandom_range(0, 3));
        5:       a = 32'h108 | 32'($urandom_range(0, 3));
        6:       a = 32'h10C + 32'($urandom_range(0, 32'hF3));
        default: a = 32'h8000_0000 | 32'($urandom);
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset with two entries queued
    for (int i = 0; i < 8; i++) step(32'h0, 32'h0, 1'b0, 1'b1);
    step(32'h100, 32'hC1, 1'b1, 1'b0);
    step(32'h100, 32'hC2, 1'b1, 1'b0);
    check("two_queued", {31'h0, tx_valid}, 32'h1);
    A = 32'h104; WE = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("midrst_status", RD, 32'h0000_0020);
    check("midrst_store_drop", {31'h0, store_drop}, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    peek("midrst_ram_clear", 32'h8, 32'h0);

    // Traffic after reset, counter restarts from zero
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 1) == 0) ? {24'h0, 8'($urandom_range(0, 255))}
                                      : (32'h100 | 32'($urandom_range(0, 15)));
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
